// File: rtl/usr_pkg.sv
// Shared encodings for the 4-bit universal shift register, its sequencer and benches.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/usr_sequencer_if.sv
// Command channel into the sequencer: valid/ready handshake plus abort.
interface usr_sequencer_if #(
  parameter int unsigned SER_W = 16,
  parameter int unsigned CNT_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [SER_W-1:0] cmd_data;
  logic             abort;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, abort,
    output cmd_ready
  );
endinterface

// File: rtl/usr_serial_feeder.sv
// Serial bit store for shift commands: loaded at accept, advanced once per RUN cycle.
module usr_serial_feeder #(
  parameter int unsigned SER_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [SER_W-1:0] data,
  output logic             next_bit
);

  logic [SER_W-1:0] sr;

  // Rotating rather than zero-filling keeps every bit live; at most SER_W bits are ever consumed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {sr[0], sr[SER_W-1:1]};
    end
  end

  assign next_bit = sr[1];

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer producing registered per-cycle controls for the universal shift register.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SER_W = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  usr_sequencer_if.slave   cmd,
  output logic [1:0]       sel,
  output logic             left_in,
  output logic             right_in,
  output logic [WIDTH-1:0] parallel_in,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] cnt_sat;
  logic             accept;
  logic             feed_next;

  always_comb begin
    cnt_sat = (cmd.cmd_count > CNT_W'(SER_W)) ? CNT_W'(SER_W) : cmd.cmd_count;
  end

  assign accept = (state == ST_IDLE) && cmd.cmd_valid;

  usr_serial_feeder #(.SER_W(SER_W)) u_feeder (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .shift    (state == ST_RUN),
    .data     (cmd.cmd_data),
    .next_bit (feed_next)
  );

  // Drive cycle 0 comes straight from cmd_data; later cycles take the feeder's upcoming bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= ST_IDLE;
      op_q          <= SEL_HOLD;
      rem           <= '0;
      sel           <= SEL_HOLD;
      left_in       <= 1'b0;
      right_in      <= 1'b0;
      parallel_in   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            cmd.cmd_ready <= 1'b0;
            op_q          <= cmd.cmd_op;
            if (cmd.cmd_op == SEL_LOAD) begin
              state       <= ST_LOAD;
              sel         <= SEL_LOAD;
              parallel_in <= cmd.cmd_data[WIDTH-1:0];
              busy        <= 1'b1;
            end else if (cnt_sat == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_RUN;
              rem      <= cnt_sat;
              sel      <= cmd.cmd_op;
              right_in <= (cmd.cmd_op == SEL_SHR) && cmd.cmd_data[0];
              left_in  <= (cmd.cmd_op == SEL_SHL) && cmd.cmd_data[0];
              busy     <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state   <= ST_DONE;
          sel     <= SEL_HOLD;
          busy    <= 1'b0;
          done    <= 1'b1;
          aborted <= cmd.abort;
        end
        ST_RUN: begin
          if ((rem == CNT_W'(1)) || cmd.abort) begin
            state    <= ST_DONE;
            rem      <= '0;
            sel      <= SEL_HOLD;
            left_in  <= 1'b0;
            right_in <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            aborted  <= cmd.abort;
          end else begin
            rem      <= rem - CNT_W'(1);
            right_in <= (op_q == SEL_SHR) && feed_next;
            left_in  <= (op_q == SEL_SHL) && feed_next;
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          done          <= 1'b0;
          aborted       <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
